command_serializer: RTL and testbench

//  Transmit side of the byte-wide command protocol consumed by the pipeline command input.
//  - Takes one parallel command (opcode + up to PAYLOAD_BYTES payload bytes) and emits it as a byte stream.
//  - Optionally waits for the one-byte response returned on the command response stream, then reports status.
//  - Used by the on-chip test driver/loader and as the bench-side stimulus source for the pipeline head.

---
 rtl/command_serializer_if.sv | 52 +++++
 rtl/command_serializer.sv | 138 +++++++++++++
 tb/tb_command_serializer.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/command_serializer_if.sv
// command_serializer_if: handshake and status bundle for command_serializer.
//   req_*          parallel command request (valid/ready)
//   tx_*           outgoing byte stream toward the pipeline command input
//   rx_*           response byte stream coming back from the command input
//   done_*, busy   completion pulse, status and response byte, activity flag
//   stray_count    saturating count of response bytes received outside WAIT_RESP
// The slave modport is used by command_serializer; master is the driver/loader side.
interface command_serializer_if #(
  parameter int PAYLOAD_BYTES = 36,
  parameter int LEN_W         = $clog2(PAYLOAD_BYTES + 1)
);
  logic                       req_valid;
  logic                       req_ready;
  logic [7:0]                 req_opcode;
  logic [LEN_W-1:0]           req_len;
  logic [8*PAYLOAD_BYTES-1:0] req_payload;
  logic                       req_expect_resp;

  logic                       tx_valid;
  logic                       tx_ready;
  logic [7:0]                 tx_data;

  logic                       rx_valid;
  logic                       rx_ready;
  logic [7:0]                 rx_data;

  logic                       done_valid;
  logic [1:0]                 done_status;
  logic [7:0]                 done_resp;
  logic                       busy;
  logic [7:0]                 stray_count;

  modport master (
    output req_valid, req_opcode, req_len, req_payload, req_expect_resp,
    input  req_ready,
    input  tx_valid, tx_data,
    output tx_ready,
    output rx_valid, rx_data,
    input  rx_ready,
    input  done_valid, done_status, done_resp, busy, stray_count
  );

  modport slave (
    input  req_valid, req_opcode, req_len, req_payload, req_expect_resp,
    output req_ready,
    output tx_valid, tx_data,
    input  tx_ready,
    input  rx_valid, rx_data,
    output rx_ready,
    output done_valid, done_status, done_resp, busy, stray_count
  );
endinterface

// File: rtl/command_serializer.sv
// command_serializer: turns one parallel command (opcode + payload) into a byte
// stream, optionally waits for a one-byte response, then pulses done with status.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous, active-high reset
//   bus   command_serializer_if.slave (request, tx stream, rx stream, status)
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | req_ready high, waiting for a command
// SEND_OP   | opcode byte presented on tx
// SEND_PAY  | payload bytes presented on tx, byte 0 first
// WAIT_RESP | waiting for the response byte or the timeout
// DONE      | one-cycle done pulse, status/resp registers already valid
module command_serializer #(
  parameter int PAYLOAD_BYTES = 36,
  parameter int LEN_W         = $clog2(PAYLOAD_BYTES + 1),
  parameter int RESP_TIMEOUT  = 1024
) (
  input logic                clk,
  input logic                rst,
  command_serializer_if.slave bus
);

  localparam int TMR_W = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(RESP_TIMEOUT - 1);
  localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(PAYLOAD_BYTES);

  typedef enum logic [2:0] {IDLE, SEND_OP, SEND_PAY, WAIT_RESP, DONE} state_t;

  state_t                     state, state_nx;
  logic [7:0]                 tx_data_q;
  logic [8*PAYLOAD_BYTES-1:0] pay_q;
  logic [LEN_W-1:0]           pay_left;
  logic                       exp_q;
  logic [TMR_W-1:0]           tmr;
  logic [1:0]                 status_q;
  logic [7:0]                 resp_q;
  logic [7:0]                 stray_q;
  logic                       accept, tx_hs, rx_hs, timeout;
  logic [LEN_W-1:0]           len_clamped;

  assign len_clamped = (bus.req_len > MAX_LEN) ? MAX_LEN : bus.req_len;
  assign accept      = bus.req_valid && bus.req_ready;
  assign tx_hs       = bus.tx_valid && bus.tx_ready;
  assign rx_hs       = bus.rx_valid && bus.rx_ready;
  assign timeout     = (tmr == '0);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx        = state;
    bus.req_ready   = 1'b0;
    bus.tx_valid    = 1'b0;
    bus.done_valid  = 1'b0;
    bus.busy        = (state != IDLE);
    // ready outputs are gated so they read 0 during any cycle with rst high
    bus.rx_ready    = !rst;
    unique case (state)
      IDLE: begin
        bus.req_ready = !rst;
        if (accept) state_nx = SEND_OP;
      end
      SEND_OP: begin
        bus.tx_valid = 1'b1;
        if (tx_hs) begin
          if (pay_left != '0) state_nx = SEND_PAY;
          else if (exp_q)     state_nx = WAIT_RESP;
          else                state_nx = DONE;
        end
      end
      SEND_PAY: begin
        bus.tx_valid = 1'b1;
        if (tx_hs && pay_left == LEN_W'(1)) state_nx = exp_q ? WAIT_RESP : DONE;
      end
      WAIT_RESP: begin
        if (rx_hs || timeout) state_nx = DONE;
      end
      DONE: begin
        bus.done_valid = 1'b1;
        state_nx       = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_data_q <= 8'h00;
      pay_q     <= '0;
      pay_left  <= '0;
      exp_q     <= 1'b0;
      tmr       <= TMR_LOAD;
      status_q  <= 2'b00;
      resp_q    <= 8'h00;
      stray_q   <= 8'h00;
    end else begin
      if (accept) begin
        tx_data_q <= bus.req_opcode;
        pay_q     <= bus.req_payload;
        pay_left  <= len_clamped;
        exp_q     <= bus.req_expect_resp;
      end
      // tx_data is preloaded with the next payload byte on every handshake so
      // back-to-back bytes go out with no bubble; pay_q shifts byte 0 out first.
      if (tx_hs) begin
        tx_data_q <= pay_q[7:0];
        pay_q     <= pay_q >> 8;
        if (state == SEND_PAY) pay_left <= pay_left - LEN_W'(1);
      end
      // down-counter: loaded outside WAIT_RESP, terminal count 0 means RESP_TIMEOUT cycles elapsed
      if (state == WAIT_RESP) tmr <= tmr - TMR_W'(1);
      else                    tmr <= TMR_LOAD;
      if (state != DONE && state_nx == DONE) begin
        if (!exp_q) begin
          status_q <= 2'b11;
          resp_q   <= 8'h00;
        end else if (rx_hs) begin
          status_q <= (bus.rx_data == 8'h00) ? 2'b00 : 2'b01;
          resp_q   <= bus.rx_data;
        end else begin
          status_q <= 2'b10;
          resp_q   <= 8'h00;
        end
      end
      if (rx_hs && state != WAIT_RESP && stray_q != 8'hFF) stray_q <= stray_q + 8'd1;
    end
  end

  assign bus.tx_data     = tx_data_q;
  assign bus.done_status = status_q;
  assign bus.done_resp   = resp_q;
  assign bus.stray_count = stray_q;

endmodule

// File: tb/tb_command_serializer.sv
`timescale 1ns/1ps
module tb_command_serializer;
  localparam int PB = 8;
  localparam int LW = $clog2(PB + 1);
  localparam int RT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  command_serializer_if #(.PAYLOAD_BYTES(PB), .LEN_W(LW)) bus();
  command_serializer #(.PAYLOAD_BYTES(PB), .LEN_W(LW), .RESP_TIMEOUT(RT)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct { logic [7:0] b; bit is_op; } txe_t;
  typedef struct { logic [1:0] st; logic [7:0] resp; } done_t;

  txe_t  exp_tx[$];
  done_t exp_done[$];
  txe_t  mon_e;
  done_t mon_d;

  int errors = 0, checks = 0;
  int cyc = 0;
  int tx_seen = 0, done_seen = 0;
  int op_cyc = 0, last_tx_cyc = 0, done_cyc = 0, acc_cyc = 0;
  int tgt_tx = 0, tgt_done = 0;
  int model_stray = 0;
  int tx_mode = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  // tx_ready pattern: 0 always ready, 1 toggling, 2 random
  always @(posedge clk) begin
    #1;
    case (tx_mode)
      0:       bus.tx_ready = 1'b1;
      1:       bus.tx_ready = ~bus.tx_ready;
      default: bus.tx_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // monitor: pops the scoreboard whenever the DUT presents a byte or a done pulse
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("tx_hold_valid", bus.tx_valid, 1);
        check("tx_hold_data", bus.tx_data, prev_data);
      end
      if (bus.tx_valid && bus.tx_ready) begin
        if (exp_tx.size() == 0) begin
          check("unexpected_tx", bus.tx_data, 32'hFFFF_FFFF);
        end else begin
          mon_e = exp_tx.pop_front();
          check("tx_byte", bus.tx_data, mon_e.b);
          if (mon_e.is_op) op_cyc = cyc;
        end
        last_tx_cyc = cyc;
        tx_seen++;
      end
      if (bus.done_valid) begin
        check("busy_at_done", bus.busy, 1);
        if (exp_done.size() == 0) begin
          check("unexpected_done", bus.done_status, 32'hFFFF_FFFF);
        end else begin
          mon_d = exp_done.pop_front();
          check("done_status", bus.done_status, mon_d.st);
          check("done_resp", bus.done_resp, mon_d.resp);
        end
        done_cyc = cyc;
        done_seen++;
      end
      prev_stall = bus.tx_valid && !bus.tx_ready;
      prev_data  = bus.tx_data;
    end
  end

  // d < 0: no response byte is driven; d >= RT: byte arrives after the timeout (stray)
  task automatic issue(input logic [7:0] op, input int len, input logic [8*PB-1:0] pay,
                       input bit expect_r, input int d, input logic [7:0] rb);
    int n, t;
    txe_t e;
    done_t dd;
    n = (len > PB) ? PB : len;
    e.b = op; e.is_op = 1'b1;
    exp_tx.push_back(e);
    for (int i = 0; i < n; i++) begin
      e.b = pay[8*i +: 8]; e.is_op = 1'b0;
      exp_tx.push_back(e);
    end
    if (!expect_r)              begin dd.st = 2'b11; dd.resp = 8'h00; end
    else if (d < 0 || d >= RT)  begin dd.st = 2'b10; dd.resp = 8'h00; end
    else                        begin dd.st = (rb == 8'h00) ? 2'b00 : 2'b01; dd.resp = rb; end
    exp_done.push_back(dd);
    tgt_tx   = tx_seen + n + 1;
    tgt_done = done_seen + 1;
    t = 0;
    @(negedge clk); #1;
    while (!bus.req_ready && t < 100) begin @(negedge clk); #1; t++; end
    check("req_ready_idle", bus.req_ready, 1);
    bus.req_opcode      = op;
    bus.req_len         = LW'(len);
    bus.req_payload     = pay;
    bus.req_expect_resp = expect_r;
    bus.req_valid       = 1'b1;
    acc_cyc = cyc;
    @(posedge clk); #1 bus.req_valid = 1'b0;
    @(negedge clk); #1;
    check("busy_after_accept", bus.busy, 1);
    check("req_ready_while_busy", bus.req_ready, 0);
  endtask

  task automatic finish_cmd(input bit expect_r, input int d, input logic [7:0] rb);
    int t;
    t = 0;
    if (expect_r) begin
      while (tx_seen < tgt_tx && t < 400) begin @(negedge clk); #1; t++; end
      check("tx_drained", tx_seen >= tgt_tx, 1);
      if (d >= 0) begin
        @(posedge clk);
        repeat (d) @(posedge clk);
        #1 bus.rx_valid = 1'b1; bus.rx_data = rb;
        @(posedge clk); #1 bus.rx_valid = 1'b0;
        if (d >= RT) model_stray = sat(model_stray + 1);
      end
    end
    t = 0;
    while (done_seen < tgt_done && t < 400) begin @(negedge clk); #1; t++; end
    check("done_seen", done_seen >= tgt_done, 1);
  endtask

  task automatic run_cmd(input logic [7:0] op, input int len, input logic [8*PB-1:0] pay,
                         input bit expect_r, input int d, input logic [7:0] rb);
    issue(op, len, pay, expect_r, d, rb);
    finish_cmd(expect_r, d, rb);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8*PB-1:0] pay;
    int len, d, base;
    bit ex;
    logic [7:0] rb;
    bus.req_valid = 1'b0; bus.req_opcode = 8'h00; bus.req_len = '0;
    bus.req_payload = '0; bus.req_expect_resp = 1'b0;
    bus.tx_ready = 1'b1; bus.rx_valid = 1'b0; bus.rx_data = 8'h00;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_rx_ready", bus.rx_ready, 0);
    check("rst_tx_valid", bus.tx_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done_valid", bus.done_valid, 0);
    check("rst_stray", bus.stray_count, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_req_ready", bus.req_ready, 1);
    check("post_rst_rx_ready", bus.rx_ready, 1);

    // 1: basic frame, latency
    tx_mode = 0;
    pay = '0; pay[23:0] = 24'hCCBBAA;
    run_cmd(8'h01, 3, pay, 1'b0, -1, 8'h00);
    check("t1_op_latency", op_cyc - acc_cyc, 1);
    check("t1_last_latency", last_tx_cyc - acc_cyc, 4);
    check("t1_done_latency", done_cyc - acc_cyc, 5);
    @(negedge clk);
    check("t1_ready_after_done", bus.req_ready, 1);
    check("t1_idle_busy", bus.busy, 0);

    // 2: same frame with toggling tx_ready
    tx_mode = 1;
    run_cmd(8'h01, 3, pay, 1'b0, -1, 8'h00);
    tx_mode = 0;

    // 3: len 0 with response ok / nack
    run_cmd(8'h10, 0, '0, 1'b1, 3, 8'h00);
    run_cmd(8'h11, 0, '0, 1'b1, 3, 8'h05);

    // 4: timeout and boundary
    pay = '0; pay[15:0] = 16'h5A3C;
    run_cmd(8'h20, 2, pay, 1'b1, -1, 8'h00);
    check("t4_timeout_latency", done_cyc - last_tx_cyc, RT + 1);
    run_cmd(8'h21, 0, '0, 1'b1, RT - 1, 8'h00);
    check("t4_last_chance_latency", done_cyc - last_tx_cyc, RT + 1);
    run_cmd(8'h22, 0, '0, 1'b1, RT, 8'h33);
    @(negedge clk);
    check("t4_late_byte_stray", bus.stray_count, model_stray);

    // 5: strays in IDLE and during SEND_PAY, then saturation
    @(posedge clk); #1 bus.rx_valid = 1'b1; bus.rx_data = 8'h77;
    repeat (3) @(posedge clk); #1 bus.rx_valid = 1'b0;
    model_stray = sat(model_stray + 3);
    @(negedge clk);
    check("t5_idle_stray", bus.stray_count, model_stray);
    pay = '0; pay[39:0] = 40'h1122334455;
    fork
      run_cmd(8'h30, 5, pay, 1'b0, -1, 8'h00);
      begin
        repeat (3) @(posedge clk); #1 bus.rx_valid = 1'b1;
        repeat (3) @(posedge clk); #1 bus.rx_valid = 1'b0;
      end
    join
    model_stray = sat(model_stray + 3);
    @(negedge clk);
    check("t5_send_stray", bus.stray_count, model_stray);
    @(posedge clk); #1 bus.rx_valid = 1'b1;
    repeat (300) @(posedge clk); #1 bus.rx_valid = 1'b0;
    model_stray = sat(model_stray + 300);
    @(negedge clk);
    check("t5_stray_saturate", bus.stray_count, model_stray);
    check("t5_fsm_idle", bus.req_ready, 1);

    // 6: reset mid-frame
    pay = '0; pay[39:0] = 40'hE5E4E3E2E1;
    base = tx_seen;
    issue(8'h40, 5, pay, 1'b0, -1, 8'h00);
    while (tx_seen < base + 3 && cyc < acc_cyc + 50) begin @(negedge clk); #1; end
    check("t6_reached_byte2", tx_seen >= base + 3, 1);
    @(posedge clk); #1 rst = 1'b1;
    exp_tx.delete();
    exp_done.delete();
    @(posedge clk); #1 rst = 1'b0;
    model_stray = 0;
    @(negedge clk);
    check("t6_tx_valid", bus.tx_valid, 0);
    check("t6_busy", bus.busy, 0);
    check("t6_done", bus.done_valid, 0);
    check("t6_stray_cleared", bus.stray_count, 0);
    base = done_seen;
    repeat (8) @(negedge clk);
    check("t6_no_done_pulse", done_seen, base);
    pay = '0; pay[15:0] = 16'h9988;
    run_cmd(8'h41, 2, pay, 1'b0, -1, 8'h00);

    // random phase
    for (int k = 0; k < 40; k++) begin
      tx_mode = $urandom_range(0, 2);
      pay = {$urandom, $urandom};
      len = $urandom_range(0, 11);
      ex = 1'($urandom_range(0, 1));
      d = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 20));
      rb = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      run_cmd(8'($urandom), len, pay, ex, d, rb);
      @(negedge clk);
      check("rand_stray", bus.stray_count, model_stray);
    end
    tx_mode = 0;
    repeat (4) @(negedge clk);
    check("end_tx_queue_empty", exp_tx.size(), 0);
    check("end_done_queue_empty", exp_done.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
